reg10_display_queue: RTL and testbench

Capture-and-pace stage that sits directly upstream of the single-digit 7-segment decoder. It watches the processor's register-file write port and captures every write to the display register (register 10). It queues those values and presents them one at a time on `reg10_out`, each held for at least `HOLD_CYCLES`, so short bursts of software writes stay readable on the display. The decoder consumes `reg10_out` combinationally.

---
 rtl/reg10_display_queue_if.sv | 9 +
 rtl/reg10_display_queue.sv | 113 +++++++++++
 tb/tb_reg10_display_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg10_display_queue_if.sv
// Register-file write port as seen by the display queue: write strobe, address and data.
interface reg10_display_queue_if;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    modport master (output ctrl_writeEnable, output ctrl_writeReg, output data_writeReg);
    modport slave  (input  ctrl_writeEnable, input  ctrl_writeReg, input  data_writeReg);
endinterface

// File: rtl/reg10_display_queue.sv
// Captures writes to one register-file address into a small FIFO and presents them
// one at a time on reg10_out, each held for at least HOLD_CYCLES cycles.
module reg10_display_queue #(
    parameter int REG_INDEX   = 10,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    reg10_display_queue_if.slave  wr,
    output logic [31:0]           reg10_out,
    output logic                  busy,
    output logic                  fifo_full,
    output logic [7:0]            drop_count
);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [0:0]     S_IDLE    = 1'b0;
    localparam logic [0:0]     S_HOLD    = 1'b1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
    localparam logic [PW:0]    DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [4:0]     IDX       = 5'(REG_INDEX);

    logic [31:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic [0:0]     r_state;
    logic [HCW-1:0] r_hold;
    logic [31:0]    r_out;
    logic           r_full;
    logic [7:0]     r_drops;

    logic           w_capture;
    logic           w_empty;
    logic           w_at_full;
    logic           w_expired;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [PW:0]    w_count_nxt;

    assign w_capture = wr.ctrl_writeEnable && (wr.ctrl_writeReg == IDX);
    assign w_empty   = (r_count == '0);
    assign w_at_full = (r_count == DEPTH_C);
    assign w_expired = (r_state == S_HOLD) && (r_hold == '0);
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_expired);
    // A full FIFO still accepts a capture when the head leaves at the same edge.
    assign w_push    = w_capture && (!w_at_full || w_pop);
    assign w_drop    = w_capture && w_at_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (PW+1)'(1);
            2'b01:   w_count_nxt = r_count - (PW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= wr.data_writeReg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_drops  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            if (w_drop && (r_drops != 8'hFF)) r_drops <= r_drops + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_out   <= '0;
        end else begin
            if (w_pop) r_out <= r_mem[r_rd_ptr];
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold  <= HOLD_LOAD;
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HCW'(1);
                    end else if (w_pop) begin
                        r_hold <= HOLD_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign reg10_out  = r_out;
    assign busy       = (r_state == S_HOLD);
    assign fifo_full  = r_full;
    assign drop_count = r_drops;
endmodule

// File: tb/tb_reg10_display_queue.sv
// Directed and randomized bench for reg10_display_queue, checked every cycle against a
// timestamp-based queue model of the capture/pace behaviour.
module tb_reg10_display_queue;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg10_out;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_count;

    reg10_display_queue_if wr_if ();

    reg10_display_queue #(.REG_INDEX(10), .HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .wr         (wr_if.slave),
        .reg10_out  (reg10_out),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending values, displayed value, and the cycle of the last pop.
    logic [31:0] m_q[$];
    logic [31:0] m_disp;
    bit          m_busy;
    int          m_drops;
    int          m_last_pop;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_disp     = '0;
        m_busy     = 1'b0;
        m_drops    = 0;
        m_last_pop = 0;
    endtask

    task automatic model_edge(input bit we, input logic [4:0] addr, input logic [31:0] data);
        bit expire, can_pop, cap;
        expire  = m_busy && (cyc == m_last_pop + HOLD);
        can_pop = (!m_busy || expire) && (m_q.size() > 0);
        cap     = we && (addr == 5'd10);
        if (can_pop) begin
            m_disp     = m_q.pop_front();
            m_last_pop = cyc;
            m_busy     = 1'b1;
        end else if (expire) begin
            m_busy = 1'b0;
        end
        if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back(data);
            else if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},  reg10_out, m_disp);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
        chk({tag, ".full"}, {31'd0, fifo_full}, {31'd0, (m_q.size() == DEPTH)});
        chk({tag, ".drop"}, {24'd0, drop_count}, 32'(m_drops));
    endtask

    task automatic step(input bit we, input logic [4:0] addr, input logic [31:0] data, input string tag);
        wr_if.ctrl_writeEnable = we;
        wr_if.ctrl_writeReg    = addr;
        wr_if.data_writeReg    = data;
        @(posedge clk);
        cyc++;
        model_edge(we, addr, data);
        #1;
        wr_if.ctrl_writeEnable = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, tag);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        rst_n = 1'b0;
        wr_if.ctrl_writeEnable = 1'b0;
        wr_if.ctrl_writeReg    = '0;
        wr_if.data_writeReg    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        step(1'b1, 5'd9, 32'd3, "filter_addr");
        step(1'b0, 5'd10, 32'd5, "filter_we");
        idle(3, "filter_idle");
        chk("filter.out0", reg10_out, 32'd0);

        step(1'b1, 5'd10, 32'd7, "single_cap");
        step(1'b0, 5'd0, 32'd0, "single_pop");
        chk("single.shown", reg10_out, 32'd7);
        idle(5, "single_hold");
        chk("single.kept", reg10_out, 32'd7);

        step(1'b1, 5'd10, 32'd1, "pace");
        step(1'b1, 5'd10, 32'd2, "pace");
        step(1'b1, 5'd10, 32'd3, "pace");
        idle(14, "pace_drain");

        for (int v = 1; v <= 8; v++) step(1'b1, 5'd10, 32'(v), "burst");
        idle(30, "burst_drain");

        step(1'b1, 5'd10, 32'hFFFF_FFFF, "wide_val");
        idle(6, "wide_drain");

        for (int i = 0; i < 400; i++) begin
            bit          we;
            logic [4:0]  addr;
            we   = ($urandom_range(0, 2) != 0);
            addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd10;
            step(we, addr, $urandom, "rand");
        end
        idle(30, "rand_drain");

        step(1'b1, 5'd10, 32'd11, "rst_mid_q");
        step(1'b1, 5'd10, 32'd12, "rst_mid_q");
        idle(1, "rst_mid_hold");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;
        idle(12, "after_rst");
        chk("after_rst.out0", reg10_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
